// File: rtl/mig_serial_add_ctrl.sv
// -----------------------------------------------------------------------------
// mig_serial_add_ctrl
//
// Bit-serial modular adder controller. One majority-logic (MIG) full-adder cell
// is reused across all bit positions of a WIDTH-bit word, one bit per clock,
// LSB first. Operands are captured on an accepted start request. The carry
// between bit positions is kept in a register. After WIDTH cycles the sum
// (mod 2^WIDTH) and the carry out of bit WIDTH-1 are published, together with
// a one-cycle done pulse. This is the shared modular-add resource for the
// SPECK round datapath.
//
// Optional feature macro: MIG_SERIAL_SUB_EN
//   When defined, the 'sub' input exists. A captured sub=1 computes
//   (a - b) mod 2^WIDTH as a + ~b + 1. In that mode cout=1 means no borrow
//   (a >= b). When the macro is undefined, the block is a pure adder.
//
// Parameters
//   WIDTH  word width in bits, legal range 2..64 (default 16, SPECK32/64)
//
// Ports
//   clk    in   rising-edge clock
//   rst    in   asynchronous, active-high reset
//   start  in   operation request, sampled only in IDLE
//   a      in   operand A, captured on accepted start
//   b      in   operand B, captured on accepted start
//   sub    in   subtract select, captured on accepted start (macro only)
//   busy   out  high while the cell is iterating (RUN)
//   done   out  one-cycle pulse, sum/cout valid
//   sum    out  result register, held until the next completion
//   cout   out  final carry out of bit WIDTH-1
// -----------------------------------------------------------------------------
module mig_serial_add_ctrl #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
`ifdef MIG_SERIAL_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Three-input majority, the only primitive of the MIG cell.
    function automatic logic maj(input logic x, input logic y, input logic z);
        return (x & y) | (x & z) | (y & z);
    endfunction

    state_t           r_state;
    state_t           w_next_state;

    logic [WIDTH-1:0] r_op_a;
    logic [WIDTH-1:0] r_op_b;
    logic             r_carry;
    logic [CNT_W-1:0] r_bitcnt;
    logic [WIDTH-1:0] r_result;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;

    logic             w_load;
    logic             w_last;
    logic [WIDTH-1:0] w_b_load;
    logic             w_carry_load;
    logic             w_cell_a;
    logic             w_cell_b;
    logic             w_cell_c;
    logic             w_sum_bit;
    logic             w_cout_bit;
    logic [WIDTH-1:0] w_result_next;

    // -------------------------------------------------------------------------
    // Operand conditioning at capture time. Subtraction is a + ~b + 1, so it
    // only changes what is loaded. The serial cell itself is identical.
    // -------------------------------------------------------------------------
`ifdef MIG_SERIAL_SUB_EN
    assign w_b_load     = sub ? ~b : b;
    assign w_carry_load = sub;
`else
    assign w_b_load     = b;
    assign w_carry_load = 1'b0;
`endif

    // -------------------------------------------------------------------------
    // MIG full-adder cell on the current LSBs and the registered carry.
    // The sum expression is XOR3 written in majority form.
    // -------------------------------------------------------------------------
    assign w_cell_a   = r_op_a[0];
    assign w_cell_b   = r_op_b[0];
    assign w_cell_c   = r_carry;
    assign w_cout_bit = maj(w_cell_a, w_cell_b, w_cell_c);
    assign w_sum_bit  = maj(maj(~w_cell_a, w_cell_b, w_cell_c),
                            ~w_cell_b,
                            maj(w_cell_a, w_cell_b, ~w_cell_c));

    // The result register fills from the MSB side. After WIDTH shifts, the
    // first computed bit has reached position 0.
    assign w_result_next = {w_sum_bit, r_result[WIDTH-1:1]};

    // -------------------------------------------------------------------------
    // FSM state register
    // -------------------------------------------------------------------------
    // NOTE: every clocked register uses non-blocking assignment, so all
    // flops sample pre-edge values regardless of process ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // -------------------------------------------------------------------------
    // FSM next-state and decoded outputs
    // -------------------------------------------------------------------------
    // NOTE: defaults come first so that every path assigns every output,
    // which keeps this block purely combinational (no latches).
    always_comb begin
        w_next_state = r_state;
        busy         = 1'b0;
        done         = 1'b0;
        w_load       = 1'b0;
        w_last       = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_load       = 1'b1;
                    w_next_state = S_RUN;
                end
            end
            S_RUN: begin
                busy = 1'b1;
                if (r_bitcnt == LAST_CNT) begin
                    w_last       = 1'b1;
                    w_next_state = S_DONE;
                end
            end
            S_DONE: begin
                // start is deliberately ignored here. No request is queued.
                done         = 1'b1;
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Serial datapath: operand shifters, carry, bit counter, result shifter
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_op_a   <= '0;
            r_op_b   <= '0;
            r_carry  <= 1'b0;
            r_bitcnt <= '0;
            r_result <= '0;
        end else if (w_load) begin
            r_op_a   <= a;
            r_op_b   <= w_b_load;
            r_carry  <= w_carry_load;
            r_bitcnt <= '0;
            r_result <= '0;
        end else if (busy) begin
            r_op_a   <= {1'b0, r_op_a[WIDTH-1:1]};
            r_op_b   <= {1'b0, r_op_b[WIDTH-1:1]};
            r_carry  <= w_cout_bit;
            r_bitcnt <= r_bitcnt + 1'b1;
            r_result <= w_result_next;
        end
    end

    // -------------------------------------------------------------------------
    // Published result. It changes only on the RUN->DONE edge, so the
    // consumer can read it at any time after done without a handshake.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sum  <= '0;
            r_cout <= 1'b0;
        end else if (w_last) begin
            r_sum  <= w_result_next;
            r_cout <= w_cout_bit;
        end
    end

    assign sum  = r_sum;
    assign cout = r_cout;

endmodule

// File: tb/tb_mig_serial_add_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mig_serial_add_ctrl
//
// Directed testbench for mig_serial_add_ctrl at WIDTH=16. Expected values are
// hand-computed constants. Inputs change and outputs are sampled on the
// falling clock edge.
// -----------------------------------------------------------------------------
module tb_mig_serial_add_ctrl;

    localparam int W = 16;

    logic         clk;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
`ifdef MIG_SERIAL_SUB_EN
    logic         sub;
`endif
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;

    int n_vec;
    int n_err;

    mig_serial_add_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
`ifdef MIG_SERIAL_SUB_EN
        .sub   (sub),
`endif
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Single operation with a one-cycle start pulse. The operands are scrambled
    // right after capture to show that later input changes have no effect.
    task automatic run_op(input logic [W-1:0] op_a, input logic [W-1:0] op_b,
                          input logic [W-1:0] exp_sum, input logic exp_cout,
                          input string tag);
        int lat;
        int busy_cnt;
        bit excl_ok;
        @(negedge clk);
        a = op_a; b = op_b; start = 1'b1;
        @(negedge clk);
        start = 1'b0; a = ~op_a; b = op_b ^ 16'h5A5A;
        lat = 1; busy_cnt = 0; excl_ok = 1'b1;
        while (!done && lat < 100) begin
            if (busy) busy_cnt++;
            @(negedge clk);
            lat++;
        end
        if (busy && done) excl_ok = 1'b0;
        check({tag, "/latency"}, 64'(lat), 64'(W + 1));
        check({tag, "/busy_cycles"}, 64'(busy_cnt), 64'(W));
        check({tag, "/busy_done_excl"}, 64'(excl_ok), 64'd1);
        check({tag, "/sum"}, 64'(sum), 64'(exp_sum));
        check({tag, "/cout"}, 64'(cout), 64'(exp_cout));
        @(negedge clk);
        check({tag, "/done_one_cycle"}, 64'(done), 64'd0);
        check({tag, "/idle_not_busy"}, 64'(busy), 64'd0);
        check({tag, "/sum_held"}, 64'(sum), 64'(exp_sum));
    endtask

    initial begin
        int done_cnt;
        int done_at [3];
        logic [W-1:0] sum_at [3];
        bit excl_ok;
        int done_seen;

        n_vec = 0; n_err = 0;
        rst = 1'b1; start = 1'b0; a = '0; b = '0;
`ifdef MIG_SERIAL_SUB_EN
        sub = 1'b0;
`endif
        repeat (2) @(negedge clk);
        check("reset/busy", 64'(busy), 64'd0);
        check("reset/done", 64'(done), 64'd0);
        check("reset/sum",  64'(sum),  64'd0);
        check("reset/cout", 64'(cout), 64'd0);
        rst = 1'b0;

        // Basic add vectors and the carry boundaries.
        run_op(16'h1234, 16'h4321, 16'h5555, 1'b0, "add_1234_4321");
        run_op(16'hFFFF, 16'h0001, 16'h0000, 1'b1, "add_ffff_0001");
        run_op(16'h8000, 16'h8000, 16'h0000, 1'b1, "add_8000_8000");
        run_op(16'hA5A5, 16'h5A5A, 16'hFFFF, 1'b0, "add_a5a5_5a5a");
        run_op(16'hFFFF, 16'hFFFF, 16'hFFFE, 1'b1, "add_ffff_ffff");
        run_op(16'h0000, 16'h0000, 16'h0000, 1'b0, "add_zero");

        // start is held high while operands change every cycle. Accepts are
        // expected at edges 0, 18 and 36 after negedge index 0. done is
        // expected at negedges 17, 35 and 53.
        // a(n)=0x1000+n and b(n)=0x2000+2n give sums 0x3000, 0x3036 and 0x306C.
        done_cnt = 0; excl_ok = 1'b1;
        for (int n = 0; n <= 56; n++) begin
            @(negedge clk);
            if (busy && done) excl_ok = 1'b0;
            if (done) begin
                if (done_cnt < 3) begin
                    done_at[done_cnt] = n;
                    sum_at[done_cnt]  = sum;
                end
                done_cnt++;
            end
            a = 16'h1000 + 16'(n);
            b = 16'h2000 + 16'(2 * n);
            start = (n <= 53);
        end
        start = 1'b0;
        check("held/done_count", 64'(done_cnt), 64'd3);
        check("held/excl", 64'(excl_ok), 64'd1);
        if (done_cnt >= 3) begin
            check("held/done0_at", 64'(done_at[0]), 64'd17);
            check("held/done1_at", 64'(done_at[1]), 64'd35);
            check("held/done2_at", 64'(done_at[2]), 64'd53);
            check("held/sum0", 64'(sum_at[0]), 64'h3000);
            check("held/sum1", 64'(sum_at[1]), 64'h3036);
            check("held/sum2", 64'(sum_at[2]), 64'h306C);
        end
        check("held/cout", 64'(cout), 64'd0);

        // Reset in the middle of RUN must abort immediately and produce no done.
        @(negedge clk);
        a = 16'h1111; b = 16'h2222; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (6) @(negedge clk);
        check("abort/busy_before", 64'(busy), 64'd1);
        rst = 1'b1;
        #1;
        check("abort/busy", 64'(busy), 64'd0);
        check("abort/done", 64'(done), 64'd0);
        check("abort/sum",  64'(sum),  64'd0);
        check("abort/cout", 64'(cout), 64'd0);
        #2;
        rst = 1'b0;
        done_seen = 0;
        repeat (30) begin
            @(negedge clk);
            if (done || busy) done_seen++;
        end
        check("abort/no_done", 64'(done_seen), 64'd0);
        run_op(16'h0003, 16'h0004, 16'h0007, 1'b0, "after_abort");

`ifdef MIG_SERIAL_SUB_EN
        sub = 1'b1;
        run_op(16'h0005, 16'h0007, 16'hFFFE, 1'b0, "sub_5_7");
        run_op(16'h0007, 16'h0005, 16'h0002, 1'b1, "sub_7_5");
        run_op(16'h1234, 16'h1234, 16'h0000, 1'b1, "sub_equal");
        sub = 1'b0;
        run_op(16'h0007, 16'h0005, 16'h000C, 1'b0, "sub_off_add");
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
